ball_controller: RTL and testbench



---
 rtl/ball_controller.sv | 165 ++++++++++++++++
 tb/tb_ball_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// Ping-pong ball controller: serves, moves and returns the ball along the LED strip,
// detects misses, speeds up per return and freezes once either score is full.
module ball_controller #(
    parameter int NUM_LEDS   = 18,
    parameter int TICK_DIV   = 5000000,
    parameter int MIN_DIV    = 1000000,
    parameter int SPEED_STEP = 250000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                button_L,
    input  logic                button_R,
    input  logic                left_full_flag,
    input  logic                right_full_flag,
    output logic [NUM_LEDS-1:0] leds,
    output logic                leds0,
    output logic                leds17,
    output logic                miss_L,
    output logic                miss_R,
    output logic [7:0]          rally_cnt,
    output logic                game_over
);

    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0] LAST_POS  = PW'(NUM_LEDS - 1);
    localparam logic [31:0]   TICK_P    = 32'(TICK_DIV);
    localparam logic [31:0]   MIN_P     = 32'(MIN_DIV);
    localparam logic [31:0]   STEP_P    = 32'(SPEED_STEP);
    localparam logic [31:0]   FLOOR_LIM = 32'(MIN_DIV + SPEED_STEP);

    typedef enum logic [2:0] {
        SERVE_L,
        SERVE_R,
        TO_LEFT,
        TO_RIGHT,
        OVER
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [31:0]         period_q, period_d;
    logic [31:0]         tick_q, tick_d;
    logic [7:0]          rally_q, rally_d;
    logic                btn_prev_l_q, btn_prev_r_q;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                miss_l_q, miss_l_d;
    logic                miss_r_q, miss_r_d;
    logic                over_q;

    logic press_l, press_r, step;
    logic [31:0] period_fast;

    assign press_l = btn_prev_l_q & ~button_L;
    assign press_r = btn_prev_r_q & ~button_R;
    assign step    = (tick_q == period_q - 32'd1);

    // Speed-up clamps to the floor before subtracting so the period never wraps.
    assign period_fast = (period_q >= FLOOR_LIM) ? (period_q - STEP_P) : MIN_P;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        period_d = period_q;
        tick_d   = tick_q;
        rally_d  = rally_q;
        miss_l_d = 1'b0;
        miss_r_d = 1'b0;

        if (state_q != OVER && (left_full_flag || right_full_flag)) begin
            state_d = OVER;
        end else begin
            case (state_q)
                SERVE_L: begin
                    pos_d  = LAST_POS;
                    tick_d = '0;
                    if (press_l) state_d = TO_RIGHT;
                end
                SERVE_R: begin
                    pos_d  = '0;
                    tick_d = '0;
                    if (press_r) state_d = TO_LEFT;
                end
                TO_RIGHT: begin
                    tick_d = step ? '0 : tick_q + 32'd1;
                    if (pos_q == '0) begin
                        if (press_r) begin
                            state_d  = TO_LEFT;
                            tick_d   = '0;
                            period_d = period_fast;
                            rally_d  = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
                        end else if (step) begin
                            state_d  = SERVE_R;
                            miss_r_d = 1'b1;
                            period_d = TICK_P;
                            rally_d  = '0;
                        end
                    end else if (step) begin
                        pos_d = pos_q - PW'(1);
                    end
                end
                TO_LEFT: begin
                    tick_d = step ? '0 : tick_q + 32'd1;
                    if (pos_q == LAST_POS) begin
                        if (press_l) begin
                            state_d  = TO_RIGHT;
                            tick_d   = '0;
                            period_d = period_fast;
                            rally_d  = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
                        end else if (step) begin
                            state_d  = SERVE_L;
                            miss_l_d = 1'b1;
                            period_d = TICK_P;
                            rally_d  = '0;
                        end
                    end else if (step) begin
                        pos_d = pos_q + PW'(1);
                    end
                end
                default: begin
                    state_d = OVER;
                end
            endcase
        end

        leds_d = '0;
        if (state_d != OVER) leds_d = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SERVE_L;
            pos_q        <= LAST_POS;
            period_q     <= TICK_P;
            tick_q       <= '0;
            rally_q      <= '0;
            btn_prev_l_q <= 1'b1;
            btn_prev_r_q <= 1'b1;
            leds_q       <= {1'b1, {(NUM_LEDS-1){1'b0}}};
            miss_l_q     <= 1'b0;
            miss_r_q     <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            period_q     <= period_d;
            tick_q       <= tick_d;
            rally_q      <= rally_d;
            btn_prev_l_q <= button_L;
            btn_prev_r_q <= button_R;
            leds_q       <= leds_d;
            miss_l_q     <= miss_l_d;
            miss_r_q     <= miss_r_d;
            over_q       <= (state_d == OVER);
        end
    end

    assign leds      = leds_q;
    assign leds0     = leds_q[0];
    assign leds17    = leds_q[NUM_LEDS-1];
    assign miss_L    = miss_l_q;
    assign miss_R    = miss_r_q;
    assign rally_cnt = rally_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: a directed table of game scenarios followed by
// random play compared cycle-by-cycle against a behavioural game model.
module tb_ball_controller;

    localparam int NUM  = 18;
    localparam int TICK = 4;
    localparam int MINP = 2;
    localparam int STEP = 1;

    logic           clk = 1'b0;
    logic           rst_n, button_L, button_R, left_full_flag, right_full_flag;
    logic [NUM-1:0] leds;
    logic           leds0, leds17, miss_L, miss_R, game_over;
    logic [7:0]     rally_cnt;

    int checks = 0;
    int errors = 0;

    ball_controller #(
        .NUM_LEDS(NUM), .TICK_DIV(TICK), .MIN_DIV(MINP), .SPEED_STEP(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_L(button_L), .button_R(button_R),
        .left_full_flag(left_full_flag), .right_full_flag(right_full_flag),
        .leds(leds), .leds0(leds0), .leds17(leds17), .miss_L(miss_L), .miss_R(miss_R),
        .rally_cnt(rally_cnt), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             btnL, btnR, flagL, flagR, rstn;
        int             cycles;
        logic [NUM-1:0] expLeds;
        bit             expMissL, expMissR;
        int             expRally;
        bit             expOver;
    } vec_t;

    vec_t tbl[$];

    // Game model: ball position, travel direction, cycles since last move.
    int mPos, mDir, mPeriod, mTimer, mRally;
    bit mOver, mServing, mMissL, mMissR, mPrevL, mPrevR;

    task automatic modelClock();
        bit pL, pR, pEnd;
        int endPos;
        if (!rst_n) begin
            mPos = NUM - 1; mServing = 1; mOver = 0; mPeriod = TICK; mTimer = 0;
            mRally = 0; mMissL = 0; mMissR = 0; mPrevL = 1; mPrevR = 1; mDir = -1;
        end else begin
            pL = mPrevL && !button_L;
            pR = mPrevR && !button_R;
            mPrevL = button_L;
            mPrevR = button_R;
            mMissL = 0;
            mMissR = 0;
            if (mOver) begin
                mOver = 1;
            end else if (left_full_flag || right_full_flag) begin
                mOver = 1;
            end else if (mServing) begin
                if (mPos == NUM - 1 && pL) begin
                    mServing = 0; mDir = -1; mTimer = 0;
                end else if (mPos == 0 && pR) begin
                    mServing = 0; mDir = 1; mTimer = 0;
                end
            end else begin
                endPos = (mDir < 0) ? 0 : NUM - 1;
                pEnd   = (mDir < 0) ? pR : pL;
                mTimer++;
                if (mPos == endPos && pEnd) begin
                    mDir    = -mDir;
                    mTimer  = 0;
                    mRally  = (mRally < 255) ? mRally + 1 : 255;
                    mPeriod = (mPeriod - STEP < MINP) ? MINP : mPeriod - STEP;
                end else if (mTimer == mPeriod) begin
                    mTimer = 0;
                    if (mPos == endPos) begin
                        if (mDir < 0) mMissR = 1; else mMissL = 1;
                        mServing = 1;
                        mPeriod  = TICK;
                        mRally   = 0;
                    end else begin
                        mPos += mDir;
                    end
                end
            end
        end
    endtask

    task automatic tickClock();
        modelClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit bl, input bit br, input bit fl, input bit fr, input bit rn);
        button_L        = bl;
        button_R        = br;
        left_full_flag  = fl;
        right_full_flag = fr;
        rst_n           = rn;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [NUM-1:0] eLeds, input bit eMissL,
                            input bit eMissR, input int eRally, input bit eOver);
        checkOutput({tag, " leds"},      32'(leds),      32'(eLeds));
        checkOutput({tag, " leds0"},     32'(leds0),     32'(eLeds[0]));
        checkOutput({tag, " leds17"},    32'(leds17),    32'(eLeds[NUM-1]));
        checkOutput({tag, " miss_L"},    32'(miss_L),    32'(eMissL));
        checkOutput({tag, " miss_R"},    32'(miss_R),    32'(eMissR));
        checkOutput({tag, " rally_cnt"}, 32'(rally_cnt), 32'(eRally));
        checkOutput({tag, " game_over"}, 32'(game_over), 32'(eOver));
    endtask

    initial begin
        logic [NUM-1:0] eLeds;

        applyStimulus(1, 1, 0, 0, 0);

        // {btnL, btnR, flagL, flagR, rstn, cycles, leds, missL, missR, rally, over}
        tbl.push_back('{1, 1, 0, 0, 0, 2,  18'h20000, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 1,  18'h20000, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 3,  18'h20000, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h10000, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 63, 18'h00002, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h00001, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1,  18'h00001, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 2,  18'h00001, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h00002, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 47, 18'h10000, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h20000, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 2,  18'h20000, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 1,  18'h20000, 0, 0, 2, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 2,  18'h10000, 0, 0, 2, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 22, 18'h00020, 0, 0, 2, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1,  18'h00020, 0, 0, 2, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 9,  18'h00001, 0, 0, 2, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1,  18'h00001, 0, 0, 3, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 2,  18'h00002, 0, 0, 3, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 32, 18'h20000, 0, 0, 3, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h20000, 0, 0, 3, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h20000, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h20000, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 1,  18'h20000, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 4,  18'h10000, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 64, 18'h00001, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 3,  18'h00001, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h00001, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1,  18'h00001, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1,  18'h00001, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 4,  18'h00002, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 1,  18'h00000, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 3,  18'h00000, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 1,  18'h20000, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 5,  18'h20000, 0, 0, 0, 0});

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].btnL, tbl[i].btnR, tbl[i].flagL, tbl[i].flagR, tbl[i].rstn);
            repeat (tbl[i].cycles) tickClock();
            checkAll($sformatf("vec%0d", i), tbl[i].expLeds, tbl[i].expMissL,
                     tbl[i].expMissR, tbl[i].expRally, tbl[i].expOver);
        end

        // Random play; resets and full-score flags are rare so rallies develop.
        for (int c = 0; c < 6000; c++) begin
            applyStimulus($urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                          $urandom_range(0, 2999) == 0, $urandom_range(0, 2999) == 0,
                          $urandom_range(0, 399) != 0);
            tickClock();
            eLeds = '0;
            if (!mOver) eLeds[mPos] = 1'b1;
            checkAll($sformatf("rand%0d", c), eLeds, mMissL, mMissR, mRally, mOver);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
